inpkt_parser: RTL and testbench

- Consumes the byte stream that leaves the input FIFO's read side: 8-bit data, first-word fall-through, empty/rd_en handshake, in the FIFO's read-clock domain.
- Parses the host packet format: 8-byte header, 4-byte header checksum, data bytes, 4-byte data checksum.
- Validates each packet and forwards data bytes to the core-side consumer through a one-deep registered output stage.
- Reports packet metadata, completion and sticky error flags.

---
 rtl/inpkt_parser.sv | 194 +++++++++++++++++++
 tb/tb_inpkt_parser.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inpkt_parser.sv
// inpkt_parser: parses the host packet stream leaving the input FIFO
// (FWFT read side) and forwards data bytes through a one-deep output stage.
//
// Packet: 8-byte header (version, type, 24-bit LE length, reserved, 16-bit
// LE ID), 4-byte header checksum, length data bytes, 4-byte data checksum.
// Both checksums are ~(sum of LE 32-bit words) mod 2^32, sent LE.
//
// Ports:
//   clk, rst_n            FIFO read clock, async active-low reset
//   din, inp_empty        FIFO byte (valid when inp_empty=0) and empty flag
//   inp_rd_en             combinational pop of the FIFO
//   dout, dout_valid,     registered data byte to the consumer, last-byte
//   dout_last, dout_rd_en flag and consumer accept
//   pkt_type, pkt_id      metadata of the current packet
//   pkt_done, pkt_ok      completion pulse and data-checksum result
//   err_*                 sticky error flags, cleared only by reset
//
// Build option: define INPKT_DATA_CKSUM_EN to verify the data checksum.
// Without it the data checksum bytes are discarded, pkt_ok is always 1 and
// err_data_cksum stays 0. The header checksum is checked in both builds.
module inpkt_parser #(
  parameter int VERSION      = 2,
  parameter int PKT_TYPE_MAX = 3,
  parameter int PKT_MAX_LEN  = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        inp_empty,
  output logic        inp_rd_en,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        dout_last,
  input  logic        dout_rd_en,
  output logic [7:0]  pkt_type,
  output logic [15:0] pkt_id,
  output logic        pkt_done,
  output logic        pkt_ok,
  output logic        err_version,
  output logic        err_type,
  output logic        err_len,
  output logic        err_hdr_cksum,
  output logic        err_data_cksum
);

  localparam logic [7:0]  VER_L  = 8'(VERSION);
  localparam logic [7:0]  TMAX_L = 8'(PKT_TYPE_MAX);
  localparam logic [31:0] LMAX_L = 32'(PKT_MAX_LEN);

  typedef enum logic [2:0] {S_HDR, S_HCK, S_DATA, S_DCK, S_ERR} state_t;

  state_t      state, state_nxt;
  logic [23:0] cnt;
  logic [63:0] hdr;
  logic [23:0] sh;
  logic [31:0] rx_word;
  logic [7:0]  f_ver, f_type;
  logic [23:0] f_len;
  logic [15:0] f_id;
  logic        hck_ok, bad_ver, bad_type, bad_len, hdr_pass;
  logic        last4, load, consumable, dck_ok;

  // The last three bytes received sit in sh; together with din they form the
  // LE word completed this cycle (checksum words and data words alike).
  assign rx_word  = {din, sh};
  assign f_ver    = hdr[7:0];
  assign f_type   = hdr[15:8];
  assign f_len    = hdr[39:16];
  assign f_id     = hdr[63:48];
  assign hck_ok   = (rx_word == ~(hdr[31:0] + hdr[63:32]));
  assign bad_ver  = (f_ver != VER_L);
  assign bad_type = (f_type == 8'd0) || (f_type > TMAX_L);
  assign bad_len  = (f_len == 24'd0) || (f_len[1:0] != 2'd0) || ({8'd0, f_len} > LMAX_L);
  assign hdr_pass = hck_ok && !bad_ver && !bad_type && !bad_len;
  assign last4    = (cnt[1:0] == 2'd3);
  assign load     = inp_rd_en && (state == S_DATA);

  always_comb begin
    consumable = 1'b0;
    state_nxt  = state;
    case (state)
      S_HDR, S_HCK, S_DCK: consumable = 1'b1;
      S_DATA:              consumable = !dout_valid || dout_rd_en;
      default:             consumable = 1'b0;
    endcase
    inp_rd_en = !inp_empty && consumable;
    if (inp_rd_en) begin
      case (state)
        S_HDR:   if (cnt[2:0] == 3'd7) state_nxt = S_HCK;
        S_HCK:   if (last4) state_nxt = hdr_pass ? S_DATA : S_ERR;
        S_DATA:  if (cnt == 24'd1) state_nxt = S_DCK;
        S_DCK:   if (last4) state_nxt = S_HDR;
        default: state_nxt = state;
      endcase
    end
  end

  // Byte capture: header shift register and the 3-byte word assembler.
  always_ff @(posedge clk) begin
    if (inp_rd_en) begin
      sh <= rx_word[31:8];
      if (state == S_HDR) hdr <= {din, hdr[63:8]};
    end
  end

  // Control, counter, output stage and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_HDR;
      cnt           <= '0;
      dout          <= '0;
      dout_valid    <= 1'b0;
      dout_last     <= 1'b0;
      pkt_type      <= '0;
      pkt_id        <= '0;
      pkt_done      <= 1'b0;
      pkt_ok        <= 1'b0;
      err_version   <= 1'b0;
      err_type      <= 1'b0;
      err_len       <= 1'b0;
      err_hdr_cksum <= 1'b0;
    end else begin
      state    <= state_nxt;
      pkt_done <= 1'b0;
      if (load) begin
        dout       <= din;
        dout_valid <= 1'b1;
        dout_last  <= (cnt == 24'd1);
      end else if (dout_rd_en) begin
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end
      if (inp_rd_en) begin
        case (state)
          S_HDR: cnt <= (cnt[2:0] == 3'd7) ? 24'd0 : cnt + 24'd1;
          S_HCK: begin
            if (last4) begin
              cnt <= '0;
              // Only the highest-priority fault is flagged.
              if (!hck_ok)       err_hdr_cksum <= 1'b1;
              else if (bad_ver)  err_version   <= 1'b1;
              else if (bad_type) err_type      <= 1'b1;
              else if (bad_len)  err_len       <= 1'b1;
              else begin
                pkt_type <= f_type;
                pkt_id   <= f_id;
                cnt      <= f_len;
              end
            end else begin
              cnt <= cnt + 24'd1;
            end
          end
          S_DATA: cnt <= cnt - 24'd1;
          S_DCK: begin
            if (last4) begin
              cnt      <= '0;
              pkt_done <= 1'b1;
              pkt_ok   <= dck_ok;
            end else begin
              cnt <= cnt + 24'd1;
            end
          end
          default: cnt <= cnt;
        endcase
      end
    end
  end

`ifdef INPKT_DATA_CKSUM_EN
  logic [31:0] acc;

  assign dck_ok = (rx_word == ~acc);

  // Length is a multiple of 4 and cnt counts down, so cnt[1:0]==1 marks the
  // fourth byte of each data word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc            <= '0;
      err_data_cksum <= 1'b0;
    end else if (inp_rd_en) begin
      if (state == S_HCK && last4)
        acc <= '0;
      else if (state == S_DATA && cnt[1:0] == 2'd1)
        acc <= acc + rx_word;
      if (state == S_DCK && last4 && !dck_ok)
        err_data_cksum <= 1'b1;
    end
  end
`else
  assign dck_ok         = 1'b1;
  assign err_data_cksum = 1'b0;
`endif

endmodule

// File: tb/tb_inpkt_parser.sv
// Scoreboard bench for inpkt_parser: a FIFO model feeds packets, a packet-level
// reference model queues the expected data bytes and completions, and a
// monitor compares them against what the DUT presents.
module tb_inpkt_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        inp_empty;
  logic        inp_rd_en;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_last;
  logic        dout_rd_en;
  logic [7:0]  pkt_type;
  logic [15:0] pkt_id;
  logic        pkt_done;
  logic        pkt_ok;
  logic        err_version, err_type, err_len, err_hdr_cksum, err_data_cksum;

  always #5 clk = ~clk;

  inpkt_parser dut (
    .clk(clk), .rst_n(rst_n), .din(din), .inp_empty(inp_empty),
    .inp_rd_en(inp_rd_en), .dout(dout), .dout_valid(dout_valid),
    .dout_last(dout_last), .dout_rd_en(dout_rd_en), .pkt_type(pkt_type),
    .pkt_id(pkt_id), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
    .err_version(err_version), .err_type(err_type), .err_len(err_len),
    .err_hdr_cksum(err_hdr_cksum), .err_data_cksum(err_data_cksum)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  fifo[$];
  logic [7:0]  pkt[$];
  logic [8:0]  exp_data[$];   // {last, byte}
  logic [24:0] exp_done[$];   // {ok, type, id}
  int          pushed = 0;
  int          consumed_exp = 0;
  logic [4:0]  m_err = '0;    // {version, type, len, hdr_cksum, data_cksum}
  bit          m_halted = 1'b0;
  int          gap_pct = 0;
  int          bp_pct = 0;
  int          stall = 0;
  int          data_seen = 0;
  bit          took = 1'b0;
  bit          drv_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] le32(input int i);
    return {pkt[i+3], pkt[i+2], pkt[i+1], pkt[i]};
  endfunction

  function automatic logic [31:0] cks(input int s, input int n);
    logic [31:0] sum = 32'd0;
    for (int i = 0; i + 3 < n; i += 4) sum += le32(s + i);
    return ~sum;
  endfunction

  // Builds a packet into pkt. Oversized lengths get no data bytes.
  task automatic build(input logic [7:0] ver, input logic [7:0] typ, input int hlen,
                       input logic [15:0] id, input bit bad_hck, input bit bad_dck);
    int dl;
    logic [31:0] c;
    logic [23:0] l24;
    dl  = (hlen <= 256) ? hlen : 0;
    l24 = 24'(hlen);
    pkt.delete();
    pkt.push_back(ver); pkt.push_back(typ);
    pkt.push_back(l24[7:0]); pkt.push_back(l24[15:8]); pkt.push_back(l24[23:16]);
    pkt.push_back(8'($urandom)); pkt.push_back(id[7:0]); pkt.push_back(id[15:8]);
    c = cks(0, 8);
    for (int b = 0; b < 4; b++) pkt.push_back(8'(c >> (8 * b)));
    if (bad_hck) pkt[8] = pkt[8] ^ 8'h01;
    for (int i = 0; i < dl; i++) pkt.push_back(8'($urandom_range(0, 255)));
    c = cks(12, dl);
    for (int b = 0; b < 4; b++) pkt.push_back(8'(c >> (8 * b)));
    if (bad_dck) pkt[pkt.size()-1] = pkt[pkt.size()-1] ^ 8'h01;
  endtask

  // Reference model: interprets pkt by the packet rules, then queues it in the FIFO.
  task automatic send_pkt();
    int          len;
    logic [7:0]  typ;
    logic [15:0] id;
    bit          ok;
    pushed += pkt.size();
    if (!m_halted) begin
      typ = pkt[1];
      len = int'({pkt[4], pkt[3], pkt[2]});
      id  = {pkt[7], pkt[6]};
      if (le32(8) != cks(0, 8))                              begin m_err[1] = 1'b1; m_halted = 1'b1; end
      else if (pkt[0] != 8'd2)                               begin m_err[4] = 1'b1; m_halted = 1'b1; end
      else if (typ == 8'd0 || typ > 8'd3)                    begin m_err[3] = 1'b1; m_halted = 1'b1; end
      else if (len == 0 || (len % 4) != 0 || len > 65536)    begin m_err[2] = 1'b1; m_halted = 1'b1; end
      if (m_halted) consumed_exp += 12;
      else begin
        for (int i = 0; i < len; i++) exp_data.push_back({(i == len - 1), pkt[12+i]});
        ok = (le32(12 + len) == cks(12, len));
`ifdef INPKT_DATA_CKSUM_EN
        if (!ok) m_err[0] = 1'b1;
`else
        ok = 1'b1;
`endif
        exp_done.push_back({ok, typ, id});
        consumed_exp += 16 + len;
      end
    end
    foreach (pkt[i]) fifo.push_back(pkt[i]);
  endtask

  // FIFO model and consumer driver.
  always begin
    @(negedge clk);
    if (took && fifo.size() > 0) void'(fifo.pop_front());
    if (fifo.size() == 0 || int'($urandom_range(0, 99)) < gap_pct) begin
      inp_empty = 1'b1;
      din = 8'($urandom);
    end else begin
      inp_empty = 1'b0;
      din = fifo[0];
    end
    drv_stall = (stall > 0);
    if (drv_stall) begin
      dout_rd_en = 1'b0;
      stall--;
    end else begin
      dout_rd_en = (int'($urandom_range(0, 99)) >= bp_pct);
    end
    #1;
    took = inp_rd_en;
    if (drv_stall && dout_valid) check("bp_hold_rd_en", 64'(inp_rd_en), 64'd0);
  end

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (dout_valid && dout_rd_en) begin
        data_seen++;
        if (exp_data.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL dout_unexpected: got %h, expected no byte", dout);
        end else check("dout", 64'({dout_last, dout}), 64'(exp_data.pop_front()));
      end
      if (pkt_done) begin
        if (exp_done.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL pkt_done_unexpected: got ok=%0d, expected no completion", pkt_ok);
        end else check("pkt_done", 64'({pkt_ok, pkt_type, pkt_id}), 64'(exp_done.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    inp_empty = 1'b1;
    #1;
    fifo.delete(); exp_data.delete(); exp_done.delete();
    took = 1'b0; pushed = 0; consumed_exp = 0; m_err = '0; m_halted = 1'b0; stall = 0;
    check(name, 64'({inp_rd_en, dout, dout_valid, dout_last, pkt_type, pkt_id, pkt_done, pkt_ok,
                     err_version, err_type, err_len, err_hdr_cksum, err_data_cksum}), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(fifo.size() == pushed - consumed_exp && exp_data.size() == 0 && exp_done.size() == 0)
           && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got %0d bytes left, expected %0d", name, fifo.size(), pushed - consumed_exp);
    end
    repeat (6) tick();
    check({name, "_errs"}, 64'({err_version, err_type, err_len, err_hdr_cksum, err_data_cksum}), 64'(m_err));
    check({name, "_consumed"}, 64'(pushed - fifo.size()), 64'(consumed_exp));
    if (m_halted) check({name, "_halt_rd_en"}, 64'(inp_rd_en), 64'd0);
  endtask

  task automatic set_p1();
    pkt = {8'h02, 8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12,
           8'hFD, 8'hFE, 8'hC3, 8'hED,
           8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
           8'hF9, 8'hF7, 8'hF5, 8'hF3};
  endtask

  initial begin
    int base;
    int n;
    rst_n = 1'b0; inp_empty = 1'b1; din = 8'h00; dout_rd_en = 1'b0;
    #12;
    check("reset_outputs", 64'({inp_rd_en, dout, dout_valid, dout_last, pkt_type, pkt_id, pkt_done, pkt_ok,
                               err_version, err_type, err_len, err_hdr_cksum, err_data_cksum}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reference packet, continuous flow.
    set_p1(); send_pkt();
    wait_idle("valid_pkt", 200);

    // Bad data checksum, then a good packet behind it.
    do_reset("reset_a");
    set_p1(); pkt[23] = 8'hF4; send_pkt();
    set_p1(); send_pkt();
    wait_idle("bad_dck", 300);

    // Version error with a correct header checksum; parser halts.
    do_reset("reset_b");
    build(8'h03, 8'h01, 8, 16'h1234, 1'b0, 1'b0); send_pkt();
    set_p1(); send_pkt();
    wait_idle("bad_version", 300);

    // Header checksum corrupted; then reset and recover.
    do_reset("reset_c");
    set_p1(); pkt[8] = 8'hFC; send_pkt();
    set_p1(); send_pkt();
    wait_idle("bad_hck", 300);
    do_reset("reset_d");
    set_p1(); send_pkt();
    wait_idle("recover", 200);

    // Forced 5-cycle backpressure mid-data.
    do_reset("reset_e");
    base = data_seen;
    set_p1(); send_pkt();
    n = 0;
    while (data_seen < base + 3 && n < 200) begin tick(); n++; end
    stall = 5;
    wait_idle("backpressure", 300);

    // Length and type faults.
    do_reset("reset_f");
    build(8'h02, 8'h01, 6, 16'hBEEF, 1'b0, 1'b0); send_pkt();
    wait_idle("bad_len6", 300);
    do_reset("reset_g");
    build(8'h02, 8'h00, 8, 16'h0042, 1'b0, 1'b0); send_pkt();
    wait_idle("bad_type0", 300);
    do_reset("reset_h");
    build(8'h02, 8'h04, 8, 16'h0042, 1'b0, 1'b0); send_pkt();
    wait_idle("bad_type4", 300);
    do_reset("reset_i");
    build(8'h02, 8'h03, 65540, 16'h0007, 1'b0, 1'b0); send_pkt();
    wait_idle("bad_len_max", 300);

    // Reset mid-data, then the next byte must start a header.
    do_reset("reset_j");
    bp_pct = 30;
    base = data_seen;
    build(8'h02, 8'h02, 64, 16'hA5A5, 1'b0, 1'b0); send_pkt();
    n = 0;
    while (data_seen < base + 4 && n < 400) begin tick(); n++; end
    do_reset("reset_mid_data");
    set_p1(); send_pkt();
    wait_idle("after_mid_reset", 400);

    // Randomized traffic with stalls on both sides.
    do_reset("reset_k");
    gap_pct = 20; bp_pct = 30;
    for (int p = 0; p < 30; p++) begin
      build(8'h02, 8'($urandom_range(1, 3)), 4 * int'($urandom_range(1, 16)),
            16'($urandom), 1'b0, ($urandom_range(0, 3) == 0));
      send_pkt();
    end
    wait_idle("random", 20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
